age_select_policy: RTL and testbench

AGE_SELECT_POLICY -- requirements
Module: age_select_policy

---
 rtl/age_select_policy_pkg.sv | 11 +
 rtl/age_select_policy_if.sv | 36 +++
 rtl/age_select_policy_age_matrix.sv | 45 ++++
 rtl/age_select_policy.sv | 97 +++++++++
 tb/tb_age_select_policy.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/age_select_policy_pkg.sv
// Shared backend parameters for the issue-queue age/select policy.
package age_select_policy_pkg;

  localparam int unsigned NUM_ENTRY_DEFAULT = 8;
  localparam int unsigned NUM_ENQ_DEFAULT   = 2;
  localparam int unsigned NUM_DEQ_DEFAULT   = 2;
  localparam int unsigned ENTRY_IDX_W       = $clog2(NUM_ENTRY_DEFAULT);

  typedef logic [ENTRY_IDX_W-1:0] entry_idx_t;

endpackage

// File: rtl/age_select_policy_if.sv
// Allocate/request/grant bundle between an issue queue and its age-select policy.
interface age_select_policy_if
  import age_select_policy_pkg::*;
#(
  parameter int unsigned NUM_ENTRY = NUM_ENTRY_DEFAULT
);

  logic [NUM_ENTRY-1:0] io_validVec;
  logic                 io_allocate_0_valid;
  logic [NUM_ENTRY-1:0] io_allocate_0_bits;
  logic                 io_allocate_1_valid;
  logic [NUM_ENTRY-1:0] io_allocate_1_bits;
  logic                 io_enq_fire_0;
  logic                 io_enq_fire_1;
  logic [NUM_ENTRY-1:0] io_request;
  logic                 io_grant_0_valid;
  logic [NUM_ENTRY-1:0] io_grant_0_bits;
  logic                 io_grant_1_valid;
  logic [NUM_ENTRY-1:0] io_grant_1_bits;
  logic                 io_flush;

  modport master (
    output io_validVec, io_enq_fire_0, io_enq_fire_1, io_request, io_flush,
    input  io_allocate_0_valid, io_allocate_0_bits,
    input  io_allocate_1_valid, io_allocate_1_bits,
    input  io_grant_0_valid, io_grant_0_bits, io_grant_1_valid, io_grant_1_bits
  );

  modport slave (
    input  io_validVec, io_enq_fire_0, io_enq_fire_1, io_request, io_flush,
    output io_allocate_0_valid, io_allocate_0_bits,
    output io_allocate_1_valid, io_allocate_1_bits,
    output io_grant_0_valid, io_grant_0_bits, io_grant_1_valid, io_grant_1_bits
  );

endinterface

// File: rtl/age_select_policy_age_matrix.sv
// Age matrix: age[i][j]=1 means entry i is older than entry j; enqueued entries become youngest.
module age_matrix
  import age_select_policy_pkg::*;
#(
  parameter int unsigned NUM_ENTRY = NUM_ENTRY_DEFAULT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                fire0,
  input  logic                                fire1,
  input  logic [NUM_ENTRY-1:0]                entry0,
  input  logic [NUM_ENTRY-1:0]                entry1,
  output logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] age
);

  logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] age_q;
  logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] age_next;

  // Port 0 is applied before port 1 so a dual enqueue leaves entry0 older than entry1.
  always_comb begin
    age_next = age_q;
    if (fire0) begin
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        if (entry0[i]) age_next[i] = '0;
        else           age_next[i] = age_next[i] | entry0;
      end
    end
    if (fire1) begin
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        if (entry1[i]) age_next[i] = '0;
        else           age_next[i] = age_next[i] | entry1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     age_q <= '0;
    else if (flush) age_q <= '0;
    else            age_q <= age_next;
  end

  assign age = age_q;

endmodule

// File: rtl/age_select_policy.sv
// Issue-queue age-ordered select: free-entry allocation plus oldest-first grant on up to two ports.
module age_select_policy
  import age_select_policy_pkg::*;
#(
  parameter int unsigned NUM_ENTRY = NUM_ENTRY_DEFAULT,
  parameter int unsigned NUM_ENQ   = NUM_ENQ_DEFAULT,
  parameter int unsigned NUM_DEQ   = NUM_DEQ_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  age_select_policy_if.slave  io
);

  logic [NUM_ENTRY-1:0]                alloc0;
  logic                                alloc0_valid;
  logic [NUM_ENTRY-1:0]                alloc_hi;
  logic                                alloc_hi_found;
  logic [NUM_ENTRY-1:0]                alloc1;
  logic                                alloc1_valid;
  logic                                fire0;
  logic                                fire1;
  logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] age;
  logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] beats;
  logic [NUM_ENTRY-1:0]                cand1;
  logic [NUM_ENTRY-1:0]                win0;
  logic [NUM_ENTRY-1:0]                win1;

  // Lowest free entry for port 0, highest free entry for port 1.
  always_comb begin
    alloc0         = '0;
    alloc0_valid   = 1'b0;
    alloc_hi       = '0;
    alloc_hi_found = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      if (!io.io_validVec[i]) begin
        if (!alloc0_valid) begin
          alloc0[i]    = 1'b1;
          alloc0_valid = 1'b1;
        end
        alloc_hi       = '0;
        alloc_hi[i]    = 1'b1;
        alloc_hi_found = 1'b1;
      end
    end
    alloc1_valid = (NUM_ENQ > 1) && alloc_hi_found && (alloc_hi != alloc0);
    alloc1       = alloc1_valid ? alloc_hi : '0;
  end

  assign fire0 = io.io_enq_fire_0 & alloc0_valid;
  assign fire1 = io.io_enq_fire_1 & alloc1_valid;

  age_matrix #(
    .NUM_ENTRY (NUM_ENTRY)
  ) u_age_matrix (
    .clock  (clock),
    .reset  (reset),
    .flush  (io.io_flush),
    .fire0  (fire0),
    .fire1  (fire1),
    .entry0 (alloc0),
    .entry1 (alloc1),
    .age    (age)
  );

  // beats[i][j]: entry j is older than entry i; unordered pairs fall back to lower index.
  always_comb begin
    beats = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      for (int unsigned j = 0; j < NUM_ENTRY; j++) begin
        if (j != i) beats[i][j] = age[j][i] | (~age[i][j] & (j < i));
      end
    end
  end

  always_comb begin
    win0  = '0;
    win1  = '0;
    cand1 = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      win0[i] = io.io_request[i] & ~(|(io.io_request & beats[i]));
    end
    if (NUM_DEQ > 1) cand1 = io.io_request & ~win0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      win1[i] = cand1[i] & ~(|(cand1 & beats[i]));
    end
  end

  assign io.io_allocate_0_valid = alloc0_valid;
  assign io.io_allocate_0_bits  = alloc0;
  assign io.io_allocate_1_valid = alloc1_valid;
  assign io.io_allocate_1_bits  = alloc1;
  assign io.io_grant_0_valid    = |win0;
  assign io.io_grant_0_bits     = win0;
  assign io.io_grant_1_valid    = |win1;
  assign io.io_grant_1_bits     = win1;

endmodule

// File: tb/tb_age_select_policy.sv
// Directed and randomized checks of age_select_policy against hand values and a timestamp model.
module tb_age_select_policy;

  logic clock;
  logic reset;

  int unsigned checks;
  int unsigned fails;

  int unsigned stamp [8];
  int unsigned ts;

  age_select_policy_if #(.NUM_ENTRY(8)) io ();

  age_select_policy #(
    .NUM_ENTRY (8),
    .NUM_ENQ   (2),
    .NUM_DEQ   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] g0, input logic [7:0] g1);
    chk({tag, ".alloc0_bits"},  io.io_allocate_0_bits, a0);
    chk({tag, ".alloc0_valid"}, {7'b0, io.io_allocate_0_valid}, {7'b0, (a0 != 8'h00)});
    chk({tag, ".alloc1_bits"},  io.io_allocate_1_bits, a1);
    chk({tag, ".alloc1_valid"}, {7'b0, io.io_allocate_1_valid}, {7'b0, (a1 != 8'h00)});
    chk({tag, ".grant0_bits"},  io.io_grant_0_bits, g0);
    chk({tag, ".grant0_valid"}, {7'b0, io.io_grant_0_valid}, {7'b0, (g0 != 8'h00)});
    chk({tag, ".grant1_bits"},  io.io_grant_1_bits, g1);
    chk({tag, ".grant1_valid"}, {7'b0, io.io_grant_1_valid}, {7'b0, (g1 != 8'h00)});
    chk({tag, ".no_dup"},       io.io_grant_0_bits & io.io_grant_1_bits, 8'h00);
  endtask

  task automatic drive(input logic [7:0] v, input logic f0, input logic f1,
                       input logic [7:0] rq, input logic fl);
    io.io_validVec   = v;
    io.io_enq_fire_0 = f0;
    io.io_enq_fire_1 = f1;
    io.io_request    = rq;
    io.io_flush      = fl;
  endtask

  // Oldest candidate = smallest timestamp, lowest index among equal stamps.
  function automatic logic [7:0] model_grant(input logic [7:0] cand);
    int best;
    logic [7:0] r;
    best = -1;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (cand[i] && (best < 0 || stamp[i] < stamp[best])) best = i;
    end
    if (best >= 0) r[best] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [7:0] v, rq, ea0, ea1, eg0, eg1;
    logic       f0, f1, fl;
    int         e0, e1;

    checks = 0;
    fails  = 0;
    ts     = 0;
    reset  = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 8'hA4, 1'b0);
    #2;
    expect_all("reset", 8'h01, 8'h80, 8'h04, 8'h20);
    cyc();
    cyc();
    expect_all("reset_hold", 8'h01, 8'h80, 8'h04, 8'h20);
    reset = 1'b1;
    cyc();

    drive(8'h1F, 1'b1, 1'b0, 8'h24, 1'b0);
    #1 expect_all("enq5", 8'h20, 8'h80, 8'h04, 8'h20);
    cyc();
    drive(8'h03, 1'b1, 1'b0, 8'h24, 1'b0);
    #1 expect_all("enq2_same_cycle", 8'h04, 8'h80, 8'h04, 8'h20);
    cyc();
    drive(8'h27, 1'b0, 1'b0, 8'h24, 1'b0);
    #1 expect_all("enq2_next_cycle", 8'h08, 8'h80, 8'h20, 8'h04);
    drive(8'h7F, 1'b1, 1'b0, 8'hA4, 1'b0);
    #1 expect_all("enq7", 8'h80, 8'h00, 8'h80, 8'h20);
    cyc();
    drive(8'hA7, 1'b0, 1'b0, 8'hA4, 1'b0);
    #1 expect_all("order_5_2_7", 8'h08, 8'h40, 8'h20, 8'h04);

    drive(8'h81, 1'b1, 1'b1, 8'h42, 1'b0);
    #1 expect_all("dual_enq", 8'h02, 8'h40, 8'h02, 8'h40);
    cyc();
    drive(8'hE7, 1'b0, 1'b0, 8'h42, 1'b0);
    #1 expect_all("dual_order", 8'h08, 8'h10, 8'h02, 8'h40);
    io.io_request = 8'h62;
    #1 expect_all("dual_vs_5", 8'h08, 8'h10, 8'h20, 8'h02);

    drive(8'h7F, 1'b1, 1'b1, 8'hC0, 1'b0);
    #1 expect_all("one_free", 8'h80, 8'h00, 8'h80, 8'h40);
    cyc();
    drive(8'hFF, 1'b1, 1'b1, 8'hC0, 1'b0);
    #1 expect_all("seven_youngest", 8'h00, 8'h00, 8'h40, 8'h80);
    cyc();
    drive(8'hFF, 1'b0, 1'b0, 8'h84, 1'b0);
    #1 expect_all("full_fire_ignored", 8'h00, 8'h00, 8'h04, 8'h80);
    io.io_request = 8'h09;
    #1 expect_all("untouched_pair", 8'h00, 8'h00, 8'h01, 8'h08);
    io.io_request = 8'h00;
    #1 expect_all("no_request", 8'h00, 8'h00, 8'h00, 8'h00);
    io.io_request = 8'h10;
    #1 expect_all("single_request", 8'h00, 8'h00, 8'h10, 8'h00);

    cyc();
    io.io_request = 8'h24;
    #1 expect_all("pre_async_reset", 8'h00, 8'h00, 8'h20, 8'h04);
    reset = 1'b0;
    #1 expect_all("async_reset", 8'h00, 8'h00, 8'h04, 8'h20);
    cyc();
    reset = 1'b1;
    cyc();
    expect_all("post_reset", 8'h00, 8'h00, 8'h04, 8'h20);

    drive(8'h1F, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc();
    drive(8'h00, 1'b1, 1'b1, 8'hA0, 1'b1);
    #1 expect_all("flush_pre", 8'h01, 8'h80, 8'h80, 8'h20);
    cyc();
    drive(8'h00, 1'b0, 1'b0, 8'h81, 1'b0);
    #1 expect_all("flush_081", 8'h01, 8'h80, 8'h01, 8'h80);
    io.io_request = 8'h21;
    #1 expect_all("flush_021", 8'h01, 8'h80, 8'h01, 8'h20);
    io.io_request = 8'hA0;
    #1 expect_all("flush_0A0", 8'h01, 8'h80, 8'h20, 8'h80);
    cyc();

    // Matrix is cleared here, matching an all-zero timestamp model.
    for (int i = 0; i < 8; i++) stamp[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      v  = 8'($urandom);
      rq = 8'($urandom);
      f0 = 1'($urandom);
      f1 = 1'($urandom);
      fl = ($urandom_range(0, 63) == 0);
      drive(v, f0, f1, rq, fl);
      ea0 = 8'h00;
      ea1 = 8'h00;
      e0  = -1;
      e1  = -1;
      for (int i = 0; i < 8; i++) if (!v[i] && e0 < 0) e0 = i;
      for (int i = 7; i >= 0; i--) if (!v[i] && e1 < 0) e1 = i;
      if (e1 == e0) e1 = -1;
      if (e0 >= 0) ea0[e0] = 1'b1;
      if (e1 >= 0) ea1[e1] = 1'b1;
      eg0 = model_grant(rq);
      eg1 = model_grant(rq & ~eg0);
      #1 expect_all("random", ea0, ea1, eg0, eg1);
      cyc();
      if (fl) begin
        for (int i = 0; i < 8; i++) stamp[i] = 0;
      end else begin
        if (f0 && e0 >= 0) begin ts++; stamp[e0] = ts; end
        if (f1 && e1 >= 0) begin ts++; stamp[e1] = ts; end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
